uart_rx_pkt_ctrl: RTL and testbench

- Sequences the UART byte receiver: drives its enable and consumes its per-byte done strobe and data byte.
- Assembles bytes into framed packets: header 0xAA, length N, N payload bytes, checksum byte.
- Validates each packet, buffers the payload and replays it on a valid/ready byte stream to downstream command logic.
- Pauses the receiver while a packet drains.

---
 rtl/uart_pkt_pkg.sv | 16 +
 rtl/uart_pkt_buf.sv | 25 ++
 rtl/uart_rx_pkt_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receive controller: state encoding,
// default packet start marker and checksum width.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } pkt_state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;
    localparam int         CSUM_W       = 8;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer for the packet controller: MAX_LEN x 8 registers,
// synchronous write port, asynchronous read port.
module uart_pkt_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Framed packet receiver (AA, len, payload, checksum) feeding a valid/ready byte stream.
// Optional packet statistics counters are enabled by defining UART_RX_PKT_STATS_EN.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_sig,
    input  logic [7:0] rx_data,
    output logic       rx_en_sig,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       err_len,
    output logic       err_csum,
    output logic       err_timeout,
    output logic       busy
`ifdef UART_RX_PKT_STATS_EN
    ,
    output logic [15:0] pkt_good_cnt,
    output logic [15:0] pkt_err_cnt
`endif
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    pkt_state_t        state, state_n;
    logic [LW-1:0]     len, len_n;
    logic [CSUM_W-1:0] sum, sum_n;
    logic [AW-1:0]     wr_idx, wr_idx_n;
    logic [AW-1:0]     rd_idx, rd_idx_n;
    logic [TW-1:0]     tmo_cnt, tmo_cnt_n;
    logic              err_len_n, err_csum_n, err_tmo_n;
    logic              buf_we;
    logic [7:0]        buf_rdata;
    logic              tmo_active, tmo_hit, wr_last, rd_last;

    uart_pkt_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_idx),
        .wdata (rx_data),
        .raddr (rd_idx),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            len         <= '0;
            sum         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            tmo_cnt     <= '0;
            err_len     <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            sum         <= sum_n;
            wr_idx      <= wr_idx_n;
            rd_idx      <= rd_idx_n;
            tmo_cnt     <= tmo_cnt_n;
            err_len     <= err_len_n;
            err_csum    <= err_csum_n;
            err_timeout <= err_tmo_n;
        end
    end

    assign tmo_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    // A byte landing on the terminal count beats the timeout.
    assign tmo_hit    = tmo_active && !rx_done_sig && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign wr_last    = (LW'(wr_idx) + LW'(1)) == len;
    assign rd_last    = (LW'(rd_idx) + LW'(1)) == len;

    always_comb begin
        state_n    = state;
        len_n      = len;
        sum_n      = sum;
        wr_idx_n   = wr_idx;
        rd_idx_n   = rd_idx;
        tmo_cnt_n  = '0;
        err_len_n  = 1'b0;
        err_csum_n = 1'b0;
        err_tmo_n  = 1'b0;
        buf_we     = 1'b0;

        if (tmo_active && !rx_done_sig) begin
            tmo_cnt_n = tmo_cnt + TW'(1);
        end

        if (tmo_hit) begin
            err_tmo_n = 1'b1;
            state_n   = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_done_sig && (rx_data == HDR_BYTE)) begin
                        state_n = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_done_sig) begin
                        if ((rx_data != 8'd0) && (int'(rx_data) <= MAX_LEN)) begin
                            len_n    = LW'(rx_data);
                            sum_n    = rx_data;
                            wr_idx_n = '0;
                            state_n  = ST_PAYLOAD;
                        end else begin
                            err_len_n = 1'b1;
                            state_n   = ST_IDLE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_done_sig) begin
                        buf_we = 1'b1;
                        sum_n  = sum + rx_data;
                        if (wr_last) begin
                            state_n = ST_CSUM;
                        end else begin
                            wr_idx_n = wr_idx + AW'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_done_sig) begin
                        if (rx_data == sum) begin
                            rd_idx_n = '0;
                            state_n  = ST_DRAIN;
                        end else begin
                            err_csum_n = 1'b1;
                            state_n    = ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_last) begin
                            state_n = ST_IDLE;
                        end else begin
                            rd_idx_n = rd_idx + AW'(1);
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // The receiver is paused for the whole drain, so buffer reads never race writes.
    assign rx_en_sig = (state != ST_DRAIN);
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = (state == ST_DRAIN) ? buf_rdata : 8'h00;
    assign out_last  = (state == ST_DRAIN) && rd_last;
    assign busy      = (state != ST_IDLE);

`ifdef UART_RX_PKT_STATS_EN
    logic good_inc, bad_inc;

    assign good_inc = (state == ST_CSUM) && (state_n == ST_DRAIN);
    assign bad_inc  = err_len_n || err_csum_n || err_tmo_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_good_cnt <= '0;
            pkt_err_cnt  <= '0;
        end else begin
            if (good_inc && (pkt_good_cnt != 16'hFFFF)) begin
                pkt_good_cnt <= pkt_good_cnt + 16'd1;
            end
            if (bad_inc && (pkt_err_cnt != 16'hFFFF)) begin
                pkt_err_cnt <= pkt_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: directed framing cases plus randomized
// packets checked against a packet-level expectation queue.
module tb_uart_rx_pkt_ctrl;

    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 20;
    localparam int ERR_LEN     = 1;
    localparam int ERR_CSUM    = 2;
    localparam int ERR_TMO     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_sig = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       rx_en_sig, out_valid, out_last, err_len, err_csum, err_timeout, busy;
    logic [7:0] out_data;
`ifdef UART_RX_PKT_STATS_EN
    logic [15:0] pkt_good_cnt, pkt_err_cnt;
`endif

    uart_rx_pkt_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_done_sig (rx_done_sig),
        .rx_data     (rx_data),
        .rx_en_sig   (rx_en_sig),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .err_len     (err_len),
        .err_csum    (err_csum),
        .err_timeout (err_timeout),
        .busy        (busy)
`ifdef UART_RX_PKT_STATS_EN
        ,
        .pkt_good_cnt (pkt_good_cnt),
        .pkt_err_cnt  (pkt_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         hsCount = 0;
    int         readyMode = 0;
    int         goodModel = 0;
    int         errModel = 0;
    logic [7:0] expData[$];
    bit         expLast[$];
    int         expErr[$];
    logic [7:0] pkt[256];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int budget = 0;
        while (!rx_en_sig && budget < 3000) begin
            tick();
            budget++;
        end
        if (!rx_en_sig) begin
            checkOutput("rx_en_wait", int'(rx_en_sig), 1);
        end
        rx_data     = b;
        rx_done_sig = 1'b1;
        tick();
        rx_done_sig = 1'b0;
    endtask

    task automatic gap(input int gapMax);
        repeat ($urandom_range(0, gapMax)) tick();
    endtask

    task automatic pushPayload(input int n);
        for (int i = 0; i < n; i++) begin
            expData.push_back(pkt[i]);
            expLast.push_back(i == n - 1);
        end
    endtask

    // Sends a full frame; expectations follow directly from the framing rules.
    task automatic sendFrame(input int lenByte, input int csumDelta, input int gapMax);
        logic [7:0] cs;
        logic [7:0] lb;
        lb = lenByte[7:0];
        if (lenByte < 1 || lenByte > MAX_LEN) begin
            expErr.push_back(ERR_LEN);
            errModel++;
            applyStimulus(8'hAA);
            gap(gapMax);
            applyStimulus(lb);
            return;
        end
        cs = lb;
        for (int i = 0; i < lenByte; i++) cs = cs + pkt[i];
        cs = cs + csumDelta[7:0];
        if (csumDelta == 0) begin
            pushPayload(lenByte);
            goodModel++;
        end else begin
            expErr.push_back(ERR_CSUM);
            errModel++;
        end
        applyStimulus(8'hAA);
        gap(gapMax);
        applyStimulus(lb);
        for (int i = 0; i < lenByte; i++) begin
            gap(gapMax);
            applyStimulus(pkt[i]);
        end
        gap(gapMax);
        applyStimulus(cs);
    endtask

    task automatic sendTruncated(input int n, input int k, input int gapMax);
        expErr.push_back(ERR_TMO);
        errModel++;
        applyStimulus(8'hAA);
        gap(gapMax);
        applyStimulus(n[7:0]);
        for (int i = 0; i < k; i++) begin
            gap(gapMax);
            applyStimulus(pkt[i]);
        end
        repeat (TIMEOUT_CYC + 3) tick();
    endtask

    task automatic waitIdle();
        int b = 0;
        while ((out_valid || !rx_en_sig || expData.size() != 0) && b < 3000) begin
            tick();
            b++;
        end
        checkOutput("drain_within_budget", int'(b < 3000), 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ~out_ready;
            endcase
        end
    end

    // Compare process: every output byte and error pulse is matched against the expectation queues.
    initial begin
        int  nErr;
        int  code;
        bit  prevStall;
        prevStall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 1'b0;
            end else begin
                nErr = int'(err_len) + int'(err_csum) + int'(err_timeout);
                if (nErr != 0) begin
                    checkOutput("err_single", nErr, 1);
                    code = err_len ? ERR_LEN : (err_csum ? ERR_CSUM : ERR_TMO);
                    if (expErr.size() == 0) begin
                        checkOutput("unexpected_err", code, 0);
                    end else begin
                        checkOutput("err_kind", code, expErr.pop_front());
                    end
                end
                if (prevStall) begin
                    checkOutput("hold_valid", int'(out_valid), 1);
                end
                if (out_valid) begin
                    checkOutput("rx_en_in_drain", int'(rx_en_sig), 0);
                    if (expData.size() == 0) begin
                        checkOutput("unexpected_valid", int'(out_valid), 0);
                    end else begin
                        checkOutput("out_data", int'(out_data), int'(expData[0]));
                        checkOutput("out_last", int'(out_last), int'(expLast[0]));
                        if (out_ready) begin
                            void'(expData.pop_front());
                            void'(expLast.pop_front());
                            hsCount++;
                        end
                    end
                end
                prevStall = out_valid && !out_ready;
            end
        end
    end

    initial begin
        int h0;
        int kind;
        int n;
        int lenByte;
        logic [7:0] g;

        repeat (3) tick();
        checkOutput("rst_rx_en", int'(rx_en_sig), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_last", int'(out_last), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_errs", int'({err_len, err_csum, err_timeout}), 0);
        checkOutput("rst_busy", int'(busy), 0);
`ifdef UART_RX_PKT_STATS_EN
        checkOutput("rst_good_cnt", int'(pkt_good_cnt), 0);
        checkOutput("rst_err_cnt", int'(pkt_err_cnt), 0);
`endif
        rst = 1'b0;
        repeat (2) tick();

        // Good packet with hand-computed checksum 03+11+22+33 = 69.
        readyMode = 0;
        expData.push_back(8'h11); expLast.push_back(1'b0);
        expData.push_back(8'h22); expLast.push_back(1'b0);
        expData.push_back(8'h33); expLast.push_back(1'b1);
        goodModel++;
        applyStimulus(8'hAA); applyStimulus(8'h03);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        applyStimulus(8'h69);
        checkOutput("good_first_valid", int'(out_valid), 1);
        checkOutput("good_first_data", int'(out_data), 8'h11);
        checkOutput("good_rx_en_low", int'(rx_en_sig), 0);
        tick(); tick();
        checkOutput("good_last_data", int'(out_data), 8'h33);
        checkOutput("good_last_flag", int'(out_last), 1);
        tick();
        checkOutput("good_valid_drop", int'(out_valid), 0);
        checkOutput("good_rx_en_back", int'(rx_en_sig), 1);
        checkOutput("good_busy_idle", int'(busy), 0);

        // Backpressure: ready toggling every cycle.
        readyMode = 2;
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        h0 = hsCount;
        sendFrame(3, 0, 0);
        waitIdle();
        checkOutput("bp_handshakes", hsCount - h0, 3);
        readyMode = 0;
        tick();

        // Bad checksum (02+01+02 = 05, not 00), then a one-byte packet.
        expErr.push_back(ERR_CSUM);
        errModel++;
        applyStimulus(8'hAA); applyStimulus(8'h02);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h00);
        checkOutput("csum_err_pulse", int'(err_csum), 1);
        checkOutput("csum_no_valid", int'(out_valid), 0);
        tick();
        checkOutput("csum_err_one_cycle", int'(err_csum), 0);
        expData.push_back(8'h05); expLast.push_back(1'b1);
        goodModel++;
        applyStimulus(8'hAA); applyStimulus(8'h01); applyStimulus(8'h05); applyStimulus(8'h06);
        waitIdle();

        // Length errors with leading garbage.
        applyStimulus(8'h55); applyStimulus(8'h12);
        checkOutput("garbage_not_busy", int'(busy), 0);
        expErr.push_back(ERR_LEN);
        errModel++;
        applyStimulus(8'hAA); applyStimulus(8'h00);
        checkOutput("len_zero_err", int'(err_len), 1);
        expErr.push_back(ERR_LEN);
        errModel++;
        applyStimulus(8'hAA); applyStimulus(8'h11);
        checkOutput("len_over_err", int'(err_len), 1);
        tick();

        // Timeout after the last byte of an unfinished packet.
        expErr.push_back(ERR_TMO);
        errModel++;
        applyStimulus(8'hAA); applyStimulus(8'h02); applyStimulus(8'h07);
        repeat (TIMEOUT_CYC - 1) tick();
        checkOutput("tmo_not_yet", int'(err_timeout), 0);
        checkOutput("tmo_busy_before", int'(busy), 1);
        tick();
        checkOutput("tmo_pulse", int'(err_timeout), 1);
        checkOutput("tmo_idle", int'(busy), 0);
        tick();
        checkOutput("tmo_one_cycle", int'(err_timeout), 0);

        // Byte on the terminal cycle wins; packet AA 02 07 08 11 completes.
        expData.push_back(8'h07); expLast.push_back(1'b0);
        expData.push_back(8'h08); expLast.push_back(1'b1);
        goodModel++;
        applyStimulus(8'hAA); applyStimulus(8'h02); applyStimulus(8'h07);
        repeat (TIMEOUT_CYC - 1) tick();
        applyStimulus(8'h08);
        checkOutput("terminal_no_tmo", int'(err_timeout), 0);
        applyStimulus(8'h11);
        waitIdle();

        // Reset after the first of three bytes is accepted.
        expData.push_back(8'h11); expLast.push_back(1'b0);
        expData.push_back(8'h22); expLast.push_back(1'b0);
        expData.push_back(8'h33); expLast.push_back(1'b1);
        applyStimulus(8'hAA); applyStimulus(8'h03);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        applyStimulus(8'h69);
        h0 = hsCount;
        tick();
        checkOutput("rst_drain_first_hs", hsCount - h0, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_drain_valid", int'(out_valid), 0);
        checkOutput("rst_drain_rx_en", int'(rx_en_sig), 1);
        checkOutput("rst_drain_busy", int'(busy), 0);
        expData.delete();
        expLast.delete();
        goodModel = 0;
        errModel  = 0;
`ifdef UART_RX_PKT_STATS_EN
        checkOutput("rst_drain_good_cnt", int'(pkt_good_cnt), 0);
        checkOutput("rst_drain_err_cnt", int'(pkt_err_cnt), 0);
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
        pkt[0] = 8'h5A; pkt[1] = 8'hA5;
        sendFrame(2, 0, 0);
        waitIdle();

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            readyMode = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hAA) g = 8'h55;
                applyStimulus(g);
            end
            for (int i = 0; i < MAX_LEN; i++) pkt[i] = 8'($urandom_range(0, 255));
            n = $urandom_range(1, MAX_LEN);
            kind = $urandom_range(0, 5);
            case (kind)
                3: begin
                    lenByte = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                    sendFrame(lenByte, 0, 3);
                end
                4:       sendFrame(n, $urandom_range(1, 255), 3);
                5:       sendTruncated(n, $urandom_range(0, n), 3);
                default: sendFrame(n, 0, 3);
            endcase
            gap(3);
        end
        waitIdle();
        repeat (3) tick();

        checkOutput("exp_errors_consumed", expErr.size(), 0);
        checkOutput("exp_bytes_consumed", expData.size(), 0);
`ifdef UART_RX_PKT_STATS_EN
        checkOutput("final_good_cnt", int'(pkt_good_cnt), goodModel);
        checkOutput("final_err_cnt", int'(pkt_err_cnt), errModel);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
